// File: rtl/mem_bus_arb.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | mem_bus_arb : three-requester memory bus arbiter with wait states.     |
// | Optional round-robin arbitration: define MEM_BUS_ARB_RR_EN.            |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module mem_bus_arb #(
  parameter int unsigned WAIT_CYC = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req,
  input  logic [2:0]  we,
  input  logic [2:0]  bw,
  input  logic [15:0] addr0,
  input  logic [15:0] addr1,
  input  logic [15:0] addr2,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  input  logic [15:0] wdata2,
  output logic [2:0]  gnt,
  output logic [2:0]  done,
  output logic [15:0] rdata,
  output logic        busy,
  output logic [15:0] MAB_in,
  output logic [15:0] MDB_in,
  output logic        MW,
  output logic        BW,
  input  logic [15:0] MDB_out
);

  localparam logic [2:0] c_wait = 3'(WAIT_CYC);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t      r_state;
  logic [2:0]  r_cnt;
  logic [2:0]  r_gnt;
  logic [2:0]  r_done;
  logic [15:0] r_rdata;
  logic        r_we;
  logic        r_bw;
  logic [15:0] r_addr;
  logic [15:0] r_wdata;

  logic [1:0]  w_win_idx;
  logic        w_win_vld;
  logic        w_access;

`ifdef MEM_BUS_ARB_RR_EN
  logic [1:0] r_ptr;
  logic [1:0] w_p1;
  logic [1:0] w_p2;

  function automatic logic [1:0] inc3(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  // Search starts at the pointer and wraps modulo three.
  always_comb begin
    w_p1      = inc3(r_ptr);
    w_p2      = inc3(w_p1);
    w_win_vld = |req;
    if (req[r_ptr])     w_win_idx = r_ptr;
    else if (req[w_p1]) w_win_idx = w_p1;
    else                w_win_idx = w_p2;
  end
`else
  always_comb begin
    w_win_vld = |req;
    if (req[1])      w_win_idx = 2'd1;
    else if (req[0]) w_win_idx = 2'd0;
    else             w_win_idx = 2'd2;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 3'd0;
      r_gnt   <= 3'd0;
      r_done  <= 3'd0;
      r_rdata <= 16'd0;
      r_we    <= 1'b0;
      r_bw    <= 1'b0;
      r_addr  <= 16'd0;
      r_wdata <= 16'd0;
`ifdef MEM_BUS_ARB_RR_EN
      r_ptr   <= 2'd0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 3'd0;
          if (w_win_vld) begin
            r_state <= ST_ACCESS;
            r_gnt   <= 3'b001 << w_win_idx;
            r_cnt   <= c_wait;
            r_we    <= we[w_win_idx];
            r_bw    <= bw[w_win_idx];
            case (w_win_idx)
              2'd0:    begin r_addr <= addr0; r_wdata <= wdata0; end
              2'd1:    begin r_addr <= addr1; r_wdata <= wdata1; end
              default: begin r_addr <= addr2; r_wdata <= wdata2; end
            endcase
`ifdef MEM_BUS_ARB_RR_EN
            r_ptr <= inc3(w_win_idx);
`endif
          end
        end
        ST_ACCESS: begin
          if (r_cnt == 3'd0) begin
            r_state <= ST_DONE;
            r_done  <= r_gnt;
            if (!r_we) r_rdata <= MDB_out;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_gnt   <= 3'd0;
          r_done  <= 3'd0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_gnt   <= 3'd0;
          r_done  <= 3'd0;
        end
      endcase
    end
  end

  // Bus drive is decoded from registered state so reset clears it at once.
  assign w_access = (r_state == ST_ACCESS);
  assign MAB_in   = w_access ? r_addr : 16'd0;
  assign MDB_in   = (w_access && r_we) ? r_wdata : 16'd0;
  assign BW       = w_access & r_bw;
  assign MW       = w_access & r_we & (r_cnt == 3'd0);
  assign busy     = (r_state != ST_IDLE);
  assign gnt      = r_gnt;
  assign done     = r_done;
  assign rdata    = r_rdata;

endmodule
`default_nettype wire
